// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared types and constants for the cartridge-port bridge
// Contents:
//   state_t    - bridge FSM states
//   ROM4_PAGE  - cpu_addr[23:16] page of the ROM4 window (0xFA0000-0xFAFFFF)
//   ROM3_PAGE  - cpu_addr[23:16] page of the ROM3 window (0xFB0000-0xFBFFFF)
//   D8_BIT     - data bit carrying the dongle D8 line
package cart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK,
    WAIT
  } state_t;

  localparam logic [7:0] ROM4_PAGE = 8'hFA;
  localparam logic [7:0] ROM3_PAGE = 8'hFB;
  localparam int         D8_BIT    = 8;

endpackage

// File: rtl/cart_port_bridge_if.sv
// rtl/cart_port_bridge_if.sv - CPU/cartridge-port signal bundle for the bridge
// Signals:
//   cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr[23:1] - 68000 bus request
//   dongle_en, dongle_d8, rom_data[15:0]                  - data sources
//   rom3_n, rom4_n, cart_a[15:1]                           - cartridge strobes/address
//   cpu_din[15:0], cpu_dtack_n                             - read data and acknowledge
// Modports:
//   master - CPU/cartridge side (drives requests and data, observes bridge outputs)
//   slave  - the bridge
interface cart_port_bridge_if;

  logic        cpu_as_n;
  logic        cpu_rw;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic [23:1] cpu_addr;
  logic        dongle_en;
  logic        dongle_d8;
  logic [15:0] rom_data;
  logic        rom3_n;
  logic        rom4_n;
  logic [15:1] cart_a;
  logic [15:0] cpu_din;
  logic        cpu_dtack_n;

  modport master (
    output cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr,
    output dongle_en, dongle_d8, rom_data,
    input  rom3_n, rom4_n, cart_a, cpu_din, cpu_dtack_n
  );

  modport slave (
    input  cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr,
    input  dongle_en, dongle_d8, rom_data,
    output rom3_n, rom4_n, cart_a, cpu_din, cpu_dtack_n
  );

endinterface

// File: rtl/cart_port_bridge.sv
// rtl/cart_port_bridge.sv - ROM3/ROM4 cartridge-port read bridge for the 68000 bus
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - cart_port_bridge_if.slave: CPU request and ROM/dongle data in;
//             rom3_n/rom4_n strobes, cart_a, cpu_din, cpu_dtack_n out (all registered)
module cart_port_bridge
  import cart_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  cart_port_bridge_if.slave bus
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_sel, w_sel;       // 1 = ROM3 window
  logic [15:1]      r_cart_a, w_cart_a;
  logic [15:0]      r_din, w_din;
  logic             r_rom3_n, w_rom3_n;
  logic             r_rom4_n, w_rom4_n;
  logic             r_dtack_n, w_dtack_n;
  logic [7:0]       w_page;
  logic             w_hit;

  assign w_page = bus.cpu_addr[23:16];
  assign w_hit  = ~bus.cpu_as_n & bus.cpu_rw & (~bus.cpu_uds_n | ~bus.cpu_lds_n)
                & ((w_page == ROM4_PAGE) | (w_page == ROM3_PAGE));

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sel     = r_sel;
    w_cart_a  = r_cart_a;
    w_din     = r_din;
    w_rom3_n  = 1'b1;
    w_rom4_n  = 1'b1;
    w_dtack_n = r_dtack_n;
    case (r_state)
      IDLE: begin
        w_dtack_n = 1'b1;
        if (w_hit) begin
          w_cart_a = bus.cpu_addr[15:1];
          w_sel    = bus.cpu_addr[16];
          w_cnt    = SETUP_LOAD;
          w_state  = SETUP;
        end
      end
      SETUP: begin
        if (bus.cpu_as_n) begin
          w_cnt   = CNT_ZERO;
          w_state = IDLE;
        end else if (r_cnt == CNT_ZERO) begin
          w_cnt    = STROBE_LOAD;
          w_state  = STROBE;
          w_rom3_n = ~r_sel;
          w_rom4_n = r_sel;
        end else begin
          w_cnt = r_cnt - CNT_ONE;
        end
      end
      STROBE: begin
        // Abort releases the strobe without capture; that rising edge still clocks the dongle.
        if (bus.cpu_as_n) begin
          w_cnt   = CNT_ZERO;
          w_state = IDLE;
        end else if (r_cnt == CNT_ZERO) begin
          // Capture while the strobe is still low: the dongle changes D8 on the rising edge.
          w_din = bus.rom_data;
          if (r_sel && bus.dongle_en) begin
            w_din[D8_BIT] = bus.dongle_d8;
          end
          w_state = ACK;
        end else begin
          w_cnt    = r_cnt - CNT_ONE;
          w_rom3_n = ~r_sel;
          w_rom4_n = r_sel;
        end
      end
      ACK: begin
        // cart_a still held here so a8 is stable across the strobe rising edge.
        w_dtack_n = 1'b0;
        w_state   = WAIT;
      end
      WAIT: begin
        if (bus.cpu_as_n) begin
          w_dtack_n = 1'b1;
          w_state   = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= CNT_ZERO;
      r_sel     <= 1'b0;
      r_cart_a  <= '0;
      r_din     <= '0;
      r_rom3_n  <= 1'b1;
      r_rom4_n  <= 1'b1;
      r_dtack_n <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_sel     <= w_sel;
      r_cart_a  <= w_cart_a;
      r_din     <= w_din;
      r_rom3_n  <= w_rom3_n;
      r_rom4_n  <= w_rom4_n;
      r_dtack_n <= w_dtack_n;
    end
  end

  assign bus.rom3_n      = r_rom3_n;
  assign bus.rom4_n      = r_rom4_n;
  assign bus.cart_a      = r_cart_a;
  assign bus.cpu_din     = r_din;
  assign bus.cpu_dtack_n = r_dtack_n;

endmodule

// File: tb/tb_cart_port_bridge.sv
// tb/tb_cart_port_bridge.sv - self-checking bench for cart_port_bridge
module tb_cart_port_bridge;

  localparam int SETUP  = 1;
  localparam int STROBE = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  cart_port_bridge_if bus ();

  cart_port_bridge #(
    .SETUP_CYCLES (SETUP),
    .STROBE_CYCLES(STROBE),
    .CNT_W        (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference: data the CPU must see for a read of byte address ba.
  function automatic logic [15:0] model_din(input logic [23:0] ba, input logic [15:0] data,
                                            input logic en, input logic d8);
    logic [15:0] r;
    r = data;
    if (ba[23:16] == 8'hFB && en) r[8] = d8;
    return r;
  endfunction

  // Drives one read; c counts clocks after the edge that sees the hit (c=0).
  task automatic run_read(input logic [23:0] ba, input logic uds, input logic lds,
                          input logic [15:0] data, input logic en, input logic d8,
                          output int f3, output int n3, output int f4, output int n4,
                          output int dt_c, output logic [15:0] din, output int a_bad,
                          output logic rel);
    f3 = -1; n3 = 0; f4 = -1; n4 = 0; dt_c = -1; din = '0; a_bad = 0; rel = 1'bx;
    @(negedge clk);
    bus.cpu_addr  = ba[23:1];
    bus.cpu_rw    = 1'b1;
    bus.cpu_uds_n = uds;
    bus.cpu_lds_n = lds;
    bus.rom_data  = data;
    bus.dongle_en = en;
    bus.dongle_d8 = d8;
    bus.cpu_as_n  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rom3_n === 1'b0) begin n3++; if (f3 < 0) f3 = c; end
      if (bus.rom4_n === 1'b0) begin n4++; if (f4 < 0) f4 = c; end
      if (bus.cart_a !== ba[15:1]) a_bad++;
      if (bus.cpu_dtack_n === 1'b0) begin
        dt_c = c;
        din  = bus.cpu_din;
        break;
      end
    end
    bus.cpu_as_n  = 1'b1;
    bus.cpu_uds_n = 1'b1;
    bus.cpu_lds_n = 1'b1;
    @(negedge clk);
    rel = bus.cpu_dtack_n;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.rom3_n !== 1'b1) begin errors++; $display("FAIL reset_rom3_n: got %b want 1", bus.rom3_n); end
    checks++; if (bus.rom4_n !== 1'b1) begin errors++; $display("FAIL reset_rom4_n: got %b want 1", bus.rom4_n); end
    checks++; if (bus.cart_a !== 15'h0) begin errors++; $display("FAIL reset_cart_a: got %h want 0", bus.cart_a); end
    checks++; if (bus.cpu_din !== 16'h0) begin errors++; $display("FAIL reset_cpu_din: got %h want 0", bus.cpu_din); end
    checks++; if (bus.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack_n: got %b want 1", bus.cpu_dtack_n); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.cpu_dtack_n !== 1'b1 || bus.rom3_n !== 1'b1) begin
      errors++; $display("FAIL reset_release_idle: dtack_n %b rom3_n %b want 1 1", bus.cpu_dtack_n, bus.rom3_n);
    end
  endtask

  task automatic test_rom3_dongle;
    int f3, n3, f4, n4, dt, ab; logic [15:0] din, data; logic rel;
    data = 16'($urandom) & 16'hFEFF;
    run_read(24'hFB0100, 1'b0, 1'b0, data, 1'b1, 1'b1, f3, n3, f4, n4, dt, din, ab, rel);
    checks++; if (f3 !== SETUP) begin errors++; $display("FAIL rom3_first_low: got %0d want %0d", f3, SETUP); end
    checks++; if (n3 !== STROBE) begin errors++; $display("FAIL rom3_low_clocks: got %0d want %0d", n3, STROBE); end
    checks++; if (n4 !== 0) begin errors++; $display("FAIL rom3_rom4_quiet: got %0d want 0", n4); end
    checks++; if (ab !== 0) begin errors++; $display("FAIL rom3_cart_a_a8: bad samples %0d want 0", ab); end
    checks++; if (dt !== SETUP + STROBE + 1) begin errors++; $display("FAIL rom3_dtack_latency: got %0d want %0d", dt, SETUP + STROBE + 1); end
    checks++; if (din !== model_din(24'hFB0100, data, 1'b1, 1'b1)) begin
      errors++; $display("FAIL rom3_din_d8: got %h want %h", din, model_din(24'hFB0100, data, 1'b1, 1'b1));
    end
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL rom3_dtack_release: got %b want 1", rel); end
  endtask

  task automatic test_rom4;
    int f3, n3, f4, n4, dt, ab; logic [15:0] din; logic rel;
    run_read(24'hFA0002, 1'b0, 1'b1, 16'hA55A, 1'b1, 1'b1, f3, n3, f4, n4, dt, din, ab, rel);
    checks++; if (f4 !== SETUP || n4 !== STROBE) begin
      errors++; $display("FAIL rom4_strobe: first %0d clocks %0d want %0d %0d", f4, n4, SETUP, STROBE);
    end
    checks++; if (n3 !== 0) begin errors++; $display("FAIL rom4_rom3_quiet: got %0d want 0", n3); end
    checks++; if (din !== 16'hA55A) begin errors++; $display("FAIL rom4_din: got %h want a55a", din); end
    checks++; if (dt !== SETUP + STROBE + 1) begin errors++; $display("FAIL rom4_dtack_latency: got %0d want %0d", dt, SETUP + STROBE + 1); end
  endtask

  task automatic test_dongle_disabled;
    int f3, n3, f4, n4, dt, ab; logic [15:0] din; logic rel;
    for (int i = 0; i < 2; i++) begin
      run_read(24'hFB0000, 1'b1, 1'b0, 16'h0000, 1'b0, i[0], f3, n3, f4, n4, dt, din, ab, rel);
      checks++; if (din !== 16'h0000 || dt !== SETUP + STROBE + 1) begin
        errors++; $display("FAIL dongle_off_din: d8 %0d got %h at %0d want 0000 at %0d", i, din, dt, SETUP + STROBE + 1);
      end
    end
  endtask

  task automatic test_random_reads;
    int f3, n3, f4, n4, dt, ab, sel; logic [15:0] din, data, exp; logic rel, en, d8, uds, lds;
    logic [23:0] ba;
    for (int i = 0; i < 10; i++) begin
      ba   = {($urandom_range(0, 1) == 1) ? 8'hFB : 8'hFA, 15'($urandom), 1'b0};
      data = 16'($urandom);
      en   = 1'($urandom);
      d8   = 1'($urandom);
      sel  = $urandom_range(0, 2);
      uds  = (sel == 2);
      lds  = (sel == 1);
      exp  = model_din(ba, data, en, d8);
      run_read(ba, uds, lds, data, en, d8, f3, n3, f4, n4, dt, din, ab, rel);
      checks++; if (din !== exp || dt !== SETUP + STROBE + 1 || ab !== 0 || rel !== 1'b1) begin
        errors++; $display("FAIL rand_read_%0d: addr %h din %h dt %0d abad %0d rel %b want %h %0d 0 1", i, ba, din, dt, ab, rel, exp, SETUP + STROBE + 1);
      end
      checks++; if ((ba[16] ? n3 : n4) !== STROBE || (ba[16] ? n4 : n3) !== 0 || (ba[16] ? f3 : f4) !== SETUP) begin
        errors++; $display("FAIL rand_strobe_%0d: addr %h rom3 %0d@%0d rom4 %0d@%0d want %0d@%0d on selected only", i, ba, n3, f3, n4, f4, STROBE, SETUP);
      end
    end
  endtask

  task automatic test_ignored;
    logic [23:0] bas [3];
    logic        rws [3];
    logic        dss [3];
    int          active;
    bas[0] = 24'hFB0000; rws[0] = 1'b0; dss[0] = 1'b0;
    bas[1] = 24'hFB0000; rws[1] = 1'b1; dss[1] = 1'b1;
    bas[2] = 24'hFC0000; rws[2] = 1'b1; dss[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      active = 0;
      @(negedge clk);
      bus.cpu_addr  = bas[k][23:1];
      bus.cpu_rw    = rws[k];
      bus.cpu_uds_n = dss[k];
      bus.cpu_lds_n = dss[k];
      bus.cpu_as_n  = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.rom3_n !== 1'b1 || bus.rom4_n !== 1'b1 || bus.cpu_dtack_n !== 1'b1) active++;
      end
      bus.cpu_as_n  = 1'b1;
      bus.cpu_rw    = 1'b1;
      bus.cpu_uds_n = 1'b1;
      bus.cpu_lds_n = 1'b1;
      checks++; if (active !== 0) begin errors++; $display("FAIL ignored_%0d: active samples %0d want 0", k, active); end
    end
  endtask

  task automatic test_abort;
    int f3, n3, f4, n4, dt, ab, bad; logic [15:0] din; logic rel;
    bad = 0;
    @(negedge clk);
    bus.cpu_addr  = 23'h7D8000;
    bus.cpu_rw    = 1'b1;
    bus.cpu_uds_n = 1'b0;
    bus.cpu_lds_n = 1'b0;
    bus.dongle_en = 1'b1;
    bus.cpu_as_n  = 1'b0;
    for (int c = 0; c <= SETUP + 2; c++) begin
      @(negedge clk);
      if (c == SETUP + 1) begin
        checks++; if (bus.rom3_n !== 1'b0) begin errors++; $display("FAIL abort_in_strobe: rom3_n %b want 0", bus.rom3_n); end
        bus.cpu_as_n = 1'b1;
      end
    end
    checks++; if (bus.rom3_n !== 1'b1) begin errors++; $display("FAIL abort_strobe_rise: rom3_n %b want 1", bus.rom3_n); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.cpu_dtack_n !== 1'b1 || bus.rom3_n !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_no_dtack: active samples %0d want 0", bad); end
    run_read(24'hFB0000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, f3, n3, f4, n4, dt, din, ab, rel);
    checks++; if (din !== 16'h1234 || dt !== SETUP + STROBE + 1 || n3 !== STROBE) begin
      errors++; $display("FAIL abort_next_read: din %h dt %0d low %0d want 1234 %0d %0d", din, dt, n3, SETUP + STROBE + 1, STROBE);
    end
  endtask

  task automatic test_reset_mid;
    int f3, n3, f4, n4, dt, ab; logic [15:0] din; logic rel;
    @(negedge clk);
    bus.cpu_addr  = 23'h7D8000;
    bus.cpu_rw    = 1'b1;
    bus.cpu_uds_n = 1'b0;
    bus.cpu_lds_n = 1'b0;
    bus.cpu_as_n  = 1'b0;
    for (int c = 0; c <= SETUP + 1; c++) @(negedge clk);
    checks++; if (bus.rom3_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_strobe: rom3_n %b want 0", bus.rom3_n); end
    reset_n      = 1'b0;
    bus.cpu_as_n = 1'b1;
    #1;
    checks++; if (bus.rom3_n !== 1'b1 || bus.cpu_dtack_n !== 1'b1) begin
      errors++; $display("FAIL rstmid_async: rom3_n %b dtack_n %b want 1 1", bus.rom3_n, bus.cpu_dtack_n);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_read(24'hFB0000, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0, f3, n3, f4, n4, dt, din, ab, rel);
    checks++; if (f3 !== SETUP || dt !== SETUP + STROBE + 1 || din !== 16'h0F0F) begin
      errors++; $display("FAIL rstmid_idle_after: first %0d dt %0d din %h want %0d %0d 0f0f", f3, dt, din, SETUP, SETUP + STROBE + 1);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.cpu_as_n  = 1'b1;
    bus.cpu_rw    = 1'b1;
    bus.cpu_uds_n = 1'b1;
    bus.cpu_lds_n = 1'b1;
    bus.cpu_addr  = '0;
    bus.dongle_en = 1'b0;
    bus.dongle_d8 = 1'b0;
    bus.rom_data  = '0;
    test_reset();
    test_rom3_dongle();
    test_rom4();
    test_dongle_disabled();
    test_random_reads();
    test_ignored();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
